// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the integer datapath and the HI/LO
// multiply/divide unit.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One multiplier/quotient bit per cycle over WIDTH cycles, then a single
// sign-fixup cycle that commits hi/lo. MTHI/MTLO write directly from IDLE.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, stateNext;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;      // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;     // |multiplicand| or |divisor|
  logic               isDiv;
  logic               negRes;   // negate product / quotient
  logic               negRem;   // negate remainder (sign of dividend)
  logic               divZero;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               doneReg;

  // Operand magnitudes; the unsigned ops have op[0]=1.
  logic             signedOp;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] aAbs, bAbs;
  assign signedOp = ~bus.op[0];
  assign aNeg     = signedOp & bus.a[WIDTH-1];
  assign bNeg     = signedOp & bus.b[WIDTH-1];
  assign aAbs     = aNeg ? (~bus.a + 1'b1) : bus.a;
  assign bAbs     = bNeg ? (~bus.b + 1'b1) : bus.b;

  // Shift-add step: add multiplicand into the upper half if the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder,
  // keep the difference when it does not go negative.
  logic [WIDTH:0]     divShift, divDiff;
  logic [2*WIDTH-1:0] divNext;
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opnd};
  assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {divDiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  // Sign fixup applied on the FIX edge.
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;
  assign prodFix = negRes ? (~acc + 1'b1) : acc;
  assign quoFix  = negRes ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign remFix  = negRem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next state: only arithmetic ops leave IDLE; MTHI/MTLO complete in place.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start && !bus.op[2]) stateNext = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath, HI/LO and done pulse. hi/lo only move on MTHI/MTLO or FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              acc     <= {{WIDTH{1'b0}}, aAbs};
              opnd    <= bAbs;
              count   <= '0;
              isDiv   <= bus.op[1];
              negRes  <= aNeg ^ bNeg;
              negRem  <= aNeg;
              divZero <= bus.op[1] & (bus.b == '0);
            end else if (bus.op == OP_MTHI) begin
              hiReg   <= bus.a;
              doneReg <= 1'b1;
            end else if (bus.op == OP_MTLO) begin
              loReg   <= bus.a;
              doneReg <= 1'b1;
            end
          end
        end
        RUN: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count + 1'b1;
        end
        FIX: begin
          if (isDiv) begin
            // Divide by zero leaves the dividend in the remainder, which the
            // sign fixup turns back into the original a.
            hiReg <= remFix;
            loReg <= divZero ? '1 : quoFix;
          end else begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected {hi,lo},
// an independent monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [63:0] expQ[$];
  logic [W-1:0] mHi = '0, mLo = '0;
  logic [63:0] monExp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: architectural results straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] h,
                                        input logic [W-1:0] l);
    logic signed [63:0] sa, sb, q, rm;
    logic [63:0] r;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      3'd3: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
      3'd4: r = {a, l};
      3'd5: r = {h, a};
      default: r = {h, l};
    endcase
    return r;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      check("doneWhileBusy", 64'(bus.busy), 64'd0);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpectedDone got hi=%h lo=%h want no done", bus.hi, bus.lo);
      end else begin
        monExp = expQ.pop_front();
        check("hilo", {bus.hi, bus.lo}, monExp);
      end
    end
  end

  // Issue one op starting at the current negedge; returns at the negedge
  // where done is observed so the next call starts back-to-back.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [63:0] expv, input int intrudeAt);
    int n, busyCnt, lat;
    logic [63:0] prev;
    prev = {mHi, mLo};
    lat  = op[2] ? 1 : 34;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    expQ.push_back(expv);
    {mHi, mLo} = expv;
    n = 0; busyCnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; end
      if (intrudeAt != 0 && n == intrudeAt) begin bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA; end
      if (intrudeAt != 0 && n == intrudeAt + 1) bus.start = 1'b0;
      if (bus.busy) begin
        busyCnt++;
        check("holdDuringRun", {bus.hi, bus.lo}, prev);
      end
    end while (!bus.done && n < 100);
    check("latency", 64'(n), 64'(lat));
    check("busyCycles", 64'(busyCnt), op[2] ? 64'd0 : 64'd33);
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b, model(op, a, b, mHi, mLo), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rstBusy", 64'(bus.busy), 64'd0);
    check("rstDone", 64'(bus.done), 64'd0);
    check("rstHiLo", {bus.hi, bus.lo}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived results.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
    issue(3'd3, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 0);
    issue(3'd1, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 10);
    issue(3'd4, 32'h0000_AAAA, 32'd0, 64'h0000_AAAA_0000_000F, 0);
    issue(3'd5, 32'h1234_5678, 32'd0, 64'h0000_AAAA_1234_5678, 0);
    issue(3'd2, 32'h8000_0005, 32'd0, 64'h8000_0005_FFFF_FFFF, 0);

    // Randomized ops, scored against the integer model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 5));
      run(op, pick(), pick());
    end

    // Reserved op: no done, no busy, hi/lo untouched.
    bus.start = 1'b1; bus.op = 3'b110; bus.a = $urandom;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      check("reservedIdle", {62'd0, bus.busy, bus.done}, 64'd0);
    end
    check("reservedHiLo", {bus.hi, bus.lo}, {mHi, mLo});

    // Reset mid-operation abandons it and clears hi/lo.
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1234; bus.b = 32'h10;
    repeat (20) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("midRstBusy", 64'(bus.busy), 64'd0);
    check("midRstDone", 64'(bus.done), 64'd0);
    check("midRstHiLo", {bus.hi, bus.lo}, 64'd0);
    mHi = '0; mLo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(3'd1, 32'd2, 32'd2, 64'h0000_0000_0000_0004, 0);

    repeat (3) @(negedge clk);
    check("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
